// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fader: FSM states, register map and the
// address of the downstream channel's duty register.
package pwm_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned ADR_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } fader_state_e;

  localparam logic [ADR_W-1:0] ADDR_TARGET    = 4'd0;
  localparam logic [ADR_W-1:0] ADDR_STEP      = 4'd1;
  localparam logic [ADR_W-1:0] ADDR_PERIOD_LO = 4'd2;
  localparam logic [ADR_W-1:0] ADDR_PERIOD_HI = 4'd3;
  localparam logic [ADR_W-1:0] ADDR_CURRENT   = 4'd4;
  localparam logic [ADR_W-1:0] ADDR_STATUS    = 4'd5;

  localparam logic [ADR_W-1:0] PWM_DUTY_ADDR  = 4'd0;

endpackage

// File: rtl/peri_tick_prescaler.sv
// Loadable down-counter that paces ramp steps.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load period_i into the counter
//   period_i     : reload value
//   zero_o       : counter has reached zero (holds there until reloaded)
module peri_tick_prescaler #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                zero_o
);

  logic [PERIOD_W-1:0] count_q;

  // Count down to zero and stick there until the next load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= period_i;
    end else if (count_q != '0) begin
      count_q <= count_q - PERIOD_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/peri_pwm_fader.sv
// Wishbone peripheral that ramps a PWM duty value towards a programmed target,
// issuing one host write to the PWM channel per step.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wb_*_i / wb_*_o       : peripheral register port (TARGET, STEP, PERIOD, CURRENT, STATUS)
//   pwm_*_o / pwm_ack_i   : host port to the channel's duty register
//   busy_o                : a ramp is in progress
module peri_pwm_fader
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DUTY_W-1:0] wb_dat_i,
  input  logic              wb_stb_i,
  output logic [DUTY_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              pwm_we_o,
  output logic [ADR_W-1:0]  pwm_adr_o,
  output logic [DUTY_W-1:0] pwm_dat_o,
  output logic              pwm_stb_o,
  input  logic              pwm_ack_i,
  output logic              busy_o
);

  localparam int unsigned PREG_W      = 16;
  localparam int unsigned PW_EFF      = (PERIOD_W < PREG_W) ? PERIOD_W : PREG_W;
  localparam logic [PREG_W-1:0] PERIOD_MASK = PREG_W'((32'd1 << PW_EFF) - 32'd1);

  fader_state_e      state_q, state_d;
  logic [DUTY_W-1:0] target_q, step_q, current_q, next_q, next_d;
  logic [PREG_W-1:0] period_q;
  logic              stb_q, busy_q;

  logic              wr_c, tgt_wr_c, load_c, cur_set_c, zero_c, ramp_up_c;
  logic [DUTY_W-1:0] tgt_eff_c, step_next_c;
  logic [8:0]        cur9_c, tgt9_c, stp9_c, sum9_c, diff9_c;

  assign wr_c     = wb_stb_i & wb_we_i;
  assign tgt_wr_c = wr_c & (wb_adr_i == ADDR_TARGET);
  // A TARGET write in the same cycle as a decision must steer that decision.
  assign tgt_eff_c = tgt_wr_c ? wb_dat_i : target_q;

  // Software-writable registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q <= '0;
      step_q   <= DUTY_W'(1);
      period_q <= '0;
    end else if (wr_c) begin
      case (wb_adr_i)
        ADDR_TARGET:    target_q       <= wb_dat_i;
        ADDR_STEP:      step_q         <= wb_dat_i;
        ADDR_PERIOD_LO: period_q[7:0]  <= wb_dat_i & PERIOD_MASK[7:0];
        ADDR_PERIOD_HI: period_q[15:8] <= wb_dat_i & PERIOD_MASK[15:8];
        default: ;
      endcase
    end
  end

  // Next duty value: clamp at target in either direction, 9-bit to avoid wrap.
  assign cur9_c    = {1'b0, current_q};
  assign tgt9_c    = {1'b0, tgt_eff_c};
  assign stp9_c    = {1'b0, step_q};
  assign sum9_c    = cur9_c + stp9_c;
  assign diff9_c   = cur9_c - tgt9_c;
  assign ramp_up_c = (tgt9_c > cur9_c);

  always_comb begin
    step_next_c = tgt_eff_c;
    if (step_q != '0) begin
      if (ramp_up_c) begin
        if (sum9_c < tgt9_c) step_next_c = sum9_c[DUTY_W-1:0];
      end else begin
        if (stp9_c < diff9_c) step_next_c = current_q - step_q;
      end
    end
  end

  peri_tick_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load_c),
    .period_i (PERIOD_W'(period_q)),
    .zero_o   (zero_c)
  );

  // FSM state and registered host-port outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      next_q    <= '0;
      current_q <= '0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      stb_q   <= (state_d == ST_WRITE);
      busy_q  <= (state_d != ST_IDLE);
      if (cur_set_c) current_q <= next_q;
    end
  end

  // Next-state logic; next_q is only updated on WAIT->WRITE so it stays stable mid-write.
  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    load_c    = 1'b0;
    cur_set_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tgt_wr_c && (wb_dat_i != current_q)) begin
          state_d = ST_WAIT;
          load_c  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (tgt_eff_c == current_q) begin
          state_d = ST_IDLE;
        end else if (zero_c) begin
          next_d  = step_next_c;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (pwm_ack_i) begin
          cur_set_c = 1'b1;
          if (next_q == tgt_eff_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            load_c  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register read mux.
  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      ADDR_TARGET:    wb_dat_o = target_q;
      ADDR_STEP:      wb_dat_o = step_q;
      ADDR_PERIOD_LO: wb_dat_o = period_q[7:0];
      ADDR_PERIOD_HI: wb_dat_o = period_q[15:8];
      ADDR_CURRENT:   wb_dat_o = current_q;
      ADDR_STATUS:    wb_dat_o = {7'd0, busy_q};
      default:        wb_dat_o = '0;
    endcase
  end

  assign wb_ack_o  = wb_stb_i;
  assign pwm_stb_o = stb_q;
  assign pwm_we_o  = stb_q;
  assign pwm_adr_o = PWM_DUTY_ADDR;
  assign pwm_dat_o = next_q;
  assign busy_o    = busy_q;

endmodule
